// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/clear commands into one-cycle s/r pulses for an SR flip-flop.
// The path is: 2-FF synchroniser, debouncer, edge request, then a lockout FSM that drops collisions.
module sr_cmd_conditioner #(
   parameter int DB_CYCLES   = 8,
   parameter int CNT_W       = 4,
   parameter int LOCK_CYCLES = 3,
   parameter int ERR_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_raw,
   input  logic             clr_raw,
   output logic             s,
   output logic             r,
   output logic             set_level,
   output logic             clr_level,
   output logic             conflict,
   output logic [ERR_W-1:0] conflict_cnt
);

   localparam int LW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam int LOCK_LAST = (LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE, SET, CLR, LOCK} state_t;

   // Bit 0 carries the set channel and bit 1 carries the clear channel.
   logic [1:0]       sync1, sync2, lvl, lvl_d, req, pend, pend_next, want;
   logic [CNT_W-1:0] cnt [2];

   // NOTE: the debounce counters are ordinary flops, so they are cleared by
   // reset like every other bit here; nothing about them needs RAM inference.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         lvl   <= '0;
         lvl_d <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // stage samples the value that was present before this edge.
         sync1 <= {clr_raw, set_raw};
         sync2 <= sync1;
         lvl_d <= lvl;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != lvl[i]) begin
               if (cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                  lvl[i] <= sync2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   assign req       = lvl & ~lvl_d;
   assign want      = req | pend;
   assign set_level = lvl[0];
   assign clr_level = lvl[1];

   state_t           state, state_next;
   logic [LW-1:0]    lock_cnt, lock_next;
   logic [ERR_W-1:0] cnt_next;
   logic             conflict_next;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next    = state;
      pend_next     = pend;
      lock_next     = lock_cnt;
      cnt_next      = conflict_cnt;
      conflict_next = 1'b0;
      case (state)
         IDLE: begin
            pend_next = '0;
            if (want[0] && want[1]) begin
               conflict_next = 1'b1;
               if (conflict_cnt != '1) cnt_next = conflict_cnt + 1'b1;
            end else if (want[0]) begin
               state_next = SET;
            end else if (want[1]) begin
               state_next = CLR;
            end
         end
         SET, CLR: begin
            pend_next  = pend | req;
            lock_next  = '0;
            state_next = (LOCK_CYCLES == 0) ? IDLE : LOCK;
         end
         LOCK: begin
            pend_next = pend | req;
            if (lock_cnt == LW'(LOCK_LAST)) state_next = IDLE;
            else                            lock_next  = lock_cnt + 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // The pulses are registered from the next state, so s and r come straight
   // from flops and cannot glitch while the state decodes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pend         <= '0;
         lock_cnt     <= '0;
         conflict_cnt <= '0;
         conflict     <= 1'b0;
         s            <= 1'b0;
         r            <= 1'b0;
      end else begin
         state        <= state_next;
         pend         <= pend_next;
         lock_cnt     <= lock_next;
         conflict_cnt <= cnt_next;
         conflict     <= conflict_next;
         s            <= (state_next == SET);
         r            <= (state_next == CLR);
      end
   end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Self-checking bench for sr_cmd_conditioner: a window/schedule model checked every cycle,
// plus hand-computed latency, spacing and saturation expectations.
module tb_sr_cmd_conditioner;

   localparam int DB = 4;
   localparam int LK = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       set_raw = 1'b0;
   logic       clr_raw = 1'b0;
   logic       s, r, set_level, clr_level, conflict;
   logic [3:0] conflict_cnt;

   int checks = 0;
   int errors = 0;

   sr_cmd_conditioner #(.DB_CYCLES(DB), .CNT_W(4), .LOCK_CYCLES(LK), .ERR_W(4)) dut (
      .clk(clk), .reset(reset), .set_raw(set_raw), .clr_raw(clr_raw),
      .s(s), .r(r), .set_level(set_level), .clr_level(clr_level),
      .conflict(conflict), .conflict_cnt(conflict_cnt)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a level flips once the last DB synchronised samples all disagree
   // with it; the command scheduler is free again LK+2 edges after a pulse.
   logic [DB+1:0] hs = '0, hc = '0;
   logic          e_sl = 0, e_cl = 0, e_s = 0, e_r = 0, e_c = 0;
   logic          m_rs = 0, m_rc = 0, m_ps = 0, m_pc = 0, ws, wc;
   logic [3:0]    e_cnt = '0;
   int            m_n = 0, m_free = 0;

   always @(posedge clk) begin
      if (!reset) begin
         hs = '0; hc = '0; e_sl = 0; e_cl = 0; e_s = 0; e_r = 0; e_c = 0;
         m_rs = 0; m_rc = 0; m_ps = 0; m_pc = 0; e_cnt = '0; m_n = 0; m_free = 0;
      end else begin
         m_n++;
         ws = m_rs | m_ps;
         wc = m_rc | m_pc;
         e_s = 0; e_r = 0; e_c = 0;
         if (m_n >= m_free) begin
            m_ps = 0; m_pc = 0;
            if (ws && wc) begin
               e_c = 1;
               if (e_cnt < 4'd15) e_cnt = e_cnt + 4'd1;
            end else if (ws) begin
               e_s = 1; m_free = m_n + LK + 2;
            end else if (wc) begin
               e_r = 1; m_free = m_n + LK + 2;
            end
         end else begin
            m_ps = m_ps | m_rs;
            m_pc = m_pc | m_rc;
         end
         hs = {hs[DB:0], set_raw};
         hc = {hc[DB:0], clr_raw};
         m_rs = 0; m_rc = 0;
         if (hs[DB+1:2] == {DB{~e_sl}}) begin e_sl = ~e_sl; m_rs = e_sl; end
         if (hc[DB+1:2] == {DB{~e_cl}}) begin e_cl = ~e_cl; m_rc = e_cl; end
      end
   end

   int cyc = 0, s_seen = 0, r_seen = 0, c_seen = 0, s_cyc = 0, r_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         check("cycle", 32'({s, r, conflict, set_level, clr_level, conflict_cnt}),
               32'({e_s, e_r, e_c, e_sl, e_cl, e_cnt}));
         check("never_s_and_r", 32'(s & r), 32'd0);
         if (s) begin s_seen++; s_cyc = cyc; end
         if (r) begin r_seen++; r_cyc = cyc; end
         if (conflict) c_seen++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int s0, r0, c0;

   initial begin
      tick(2);
      check("reset_outputs", 32'({s, r, conflict, set_level, clr_level, conflict_cnt}), 32'd0);
      tick(1);
      reset = 1'b1;
      tick(4);

      // Clean set: level after E5, s for exactly one cycle after E6.
      s0 = s_seen; r0 = r_seen;
      set_raw = 1'b1;
      tick(5); check("t1_level_before_e5", 32'(set_level), 32'd0);
      tick(1); check("t1_level_after_e5", 32'(set_level), 32'd1);
               check("t1_s_before_e6", 32'(s), 32'd0);
      tick(1); check("t1_s_after_e6", 32'(s), 32'd1);
               check("t1_r_quiet", 32'(r), 32'd0);
      tick(1); check("t1_s_one_cycle", 32'(s), 32'd0);
      set_raw = 1'b0;
      tick(12);
      check("t1_pulse_count", 32'(s_seen - s0), 32'd1);
      check("t1_no_r", 32'(r_seen - r0), 32'd0);

      // Bounce: 3-high/3-low for 30 cycles never holds for 4 samples.
      s0 = s_seen;
      for (int i = 0; i < 30; i++) begin
         set_raw = ((i % 6) < 3);
         tick(1);
      end
      set_raw = 1'b0;
      tick(10);
      check("t2_level_low", 32'(set_level), 32'd0);
      check("t2_no_s", 32'(s_seen - s0), 32'd0);

      // Simultaneous set and clear.
      s0 = s_seen; r0 = r_seen; c0 = c_seen;
      set_raw = 1'b1; clr_raw = 1'b1;
      tick(15);
      check("t3_no_s", 32'(s_seen - s0), 32'd0);
      check("t3_no_r", 32'(r_seen - r0), 32'd0);
      check("t3_one_conflict", 32'(c_seen - c0), 32'd1);
      check("t3_cnt", 32'(conflict_cnt), 32'd1);
      set_raw = 1'b0; clr_raw = 1'b0;
      tick(12);

      // Set arrives during lockout: served with 4 idle cycles after r.
      s0 = s_seen; r0 = r_seen;
      clr_raw = 1'b1;
      tick(2);
      set_raw = 1'b1;
      tick(25);
      check("t4_one_r", 32'(r_seen - r0), 32'd1);
      check("t4_one_s", 32'(s_seen - s0), 32'd1);
      check("t4_spacing", 32'(s_cyc - r_cyc), 32'd5);
      set_raw = 1'b0; clr_raw = 1'b0;
      tick(12);

      // Saturation: 20 more collisions on top of the first one.
      c0 = c_seen;
      for (int i = 0; i < 20; i++) begin
         set_raw = 1'b1; clr_raw = 1'b1;
         tick(8);
         set_raw = 1'b0; clr_raw = 1'b0;
         tick(8);
         if (i == 14) check("t5_reaches_15", 32'(conflict_cnt), 32'd15);
      end
      check("t5_holds_15", 32'(conflict_cnt), 32'd15);
      check("t5_conflicts", 32'(c_seen - c0), 32'd20);
      tick(4);

      // Asynchronous reset in the middle of the SET cycle.
      set_raw = 1'b1;
      tick(7);
      check("t6_s_before_reset", 32'(s), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t6_s_async_clear", 32'(s), 32'd0);
      check("t6_level_cleared", 32'(set_level), 32'd0);
      check("t6_cnt_cleared", 32'(conflict_cnt), 32'd0);
      tick(2);
      reset = 1'b1;
      s0 = s_seen;
      tick(6);
      check("t6_level_again", 32'(set_level), 32'd1);
      check("t6_s_not_yet", 32'(s), 32'd0);
      tick(1);
      check("t6_fresh_s", 32'(s), 32'd1);
      tick(1);
      check("t6_s_one_cycle", 32'(s), 32'd0);
      check("t6_pulse_count", 32'(s_seen - s0), 32'd1);
      set_raw = 1'b0;
      tick(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
